// File: rtl/cp0_trap_seq.sv
// Trap/ERET sequencer: arbitrates exception requests, stalls the core and issues the ordered
// EPC -> Cause -> Status CP0 writes before redirecting the PC. Optional IRQ inputs: CP0_TRAP_IRQ_EN.
module cp0_trap_seq #(
    parameter logic [31:0] VECTOR = 32'h0040_0004,
    parameter int          CNT_W  = 16,
    parameter int          IRQ_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_syscall,
    input  logic             exc_break,
    input  logic             exc_teq,
    input  logic             eret_req,
`ifdef CP0_TRAP_IRQ_EN
    input  logic [IRQ_W-1:0] irq,
`endif
    input  logic [31:0]      pc_in,
    input  logic [31:0]      status_in,
    input  logic [31:0]      epc_in,
    output logic             stall,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [2:0] {
        IDLE, T_EPC, T_CAUSE, T_STAT, T_JMP, E_STAT, E_JMP
    } state_t;

    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_BRK = 5'd9;
    localparam logic [4:0] CODE_TEQ = 5'd13;
    localparam logic [4:0] CODE_IRQ = 5'd0;

    state_t           state_q, state_d;
    logic [31:0]      pc_lat_q, pc_lat_d;
    logic [4:0]       code_q, code_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    logic             cp0_we_q, cp0_we_d;
    logic [4:0]       cp0_waddr_q, cp0_waddr_d;
    logic [31:0]      cp0_wdata_q, cp0_wdata_d;
    logic             pc_redirect_q, pc_redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             busy_q, busy_d;

    logic irq_hit;
    logic sys_en, brk_en, teq_en, take;

`ifdef CP0_TRAP_IRQ_EN
    assign irq_hit = |(irq & status_in[8+IRQ_W-1:8]);
`else
    assign irq_hit = 1'b0;
`endif

    assign sys_en = status_in[1] & exc_syscall;
    assign brk_en = status_in[2] & exc_break;
    assign teq_en = status_in[3] & exc_teq;
    assign take   = status_in[0] & (sys_en | brk_en | teq_en | irq_hit);

    // Next state plus the registered output values belonging to that next state.
    always_comb begin
        state_d       = state_q;
        pc_lat_d      = pc_lat_q;
        code_d        = code_q;
        trap_cnt_d    = trap_cnt_q;
        cp0_we_d      = 1'b0;
        cp0_waddr_d   = 5'd0;
        cp0_wdata_d   = 32'd0;
        pc_redirect_d = 1'b0;
        redirect_pc_d = 32'd0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d    = T_EPC;
                    pc_lat_d   = pc_in;
                    trap_cnt_d = trap_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (sys_en)      code_d = CODE_SYS;
                    else if (brk_en) code_d = CODE_BRK;
                    else if (teq_en) code_d = CODE_TEQ;
                    else             code_d = CODE_IRQ;
                end else if (eret_req) begin
                    state_d = E_STAT;
                end
            end
            T_EPC:   state_d = T_CAUSE;
            T_CAUSE: state_d = T_STAT;
            T_STAT:  state_d = T_JMP;
            T_JMP:   state_d = IDLE;
            E_STAT:  state_d = E_JMP;
            E_JMP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The core is frozen throughout, so status_in/epc_in sampled one cycle early are stable.
        case (state_d)
            T_EPC: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = 5'd14;
                cp0_wdata_d = pc_lat_d;
            end
            T_CAUSE: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = 5'd13;
                cp0_wdata_d = {25'd0, code_d, 2'b00};
            end
            T_STAT: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = 5'd12;
                cp0_wdata_d = status_in << 5;
            end
            T_JMP: begin
                pc_redirect_d = 1'b1;
                redirect_pc_d = VECTOR;
            end
            E_STAT: begin
                cp0_we_d    = 1'b1;
                cp0_waddr_d = 5'd12;
                cp0_wdata_d = status_in >> 5;
            end
            E_JMP: begin
                pc_redirect_d = 1'b1;
                redirect_pc_d = epc_in;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_lat_q      <= 32'd0;
            code_q        <= 5'd0;
            trap_cnt_q    <= '0;
            cp0_we_q      <= 1'b0;
            cp0_waddr_q   <= 5'd0;
            cp0_wdata_q   <= 32'd0;
            pc_redirect_q <= 1'b0;
            redirect_pc_q <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_lat_q      <= pc_lat_d;
            code_q        <= code_d;
            trap_cnt_q    <= trap_cnt_d;
            cp0_we_q      <= cp0_we_d;
            cp0_waddr_q   <= cp0_waddr_d;
            cp0_wdata_q   <= cp0_wdata_d;
            pc_redirect_q <= pc_redirect_d;
            redirect_pc_q <= redirect_pc_d;
            busy_q        <= busy_d;
        end
    end

    // The accepting instruction must be held in the very cycle it is seen.
    assign stall       = busy_q | (~rst & (state_q == IDLE) & (take | eret_req));
    assign cp0_we      = cp0_we_q;
    assign cp0_waddr   = cp0_waddr_q;
    assign cp0_wdata   = cp0_wdata_q;
    assign pc_redirect = pc_redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign busy        = busy_q;
    assign trap_cnt    = trap_cnt_q;

endmodule
